mealy_seq_ctrl: RTL and testbench

Sequencer for the 5-state serial Mealy detector. It holds a loaded bit pattern and clears the detector before each run. It then drives the pattern into the detector's x1 input one bit per clock, LSB first, and captures the z1 response per bit. It sits between the chip I/O wrapper and the detector core, turning the single-bit FSM into a start/done-controlled test engine.

---
 rtl/mealy_pkg.sv | 32 +++
 rtl/mealy_fsm_core.sv | 36 +++
 rtl/mealy_seq_ctrl.sv | 106 ++++++++++
 tb/tb_mealy_seq_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mealy_pkg.sv
// Shared types and defaults for the Mealy detector core and its run sequencer.
package mealy_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int CNT_W_DEF = 4;
    localparam int LEN_W     = 4;

    typedef enum logic [2:0] {
        DET_A = 3'b000,
        DET_B = 3'b001,
        DET_D = 3'b010,
        DET_C = 3'b011,
        DET_E = 3'b100
    } det_state_t;

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        RUN,
        DONE
    } ctrl_state_t;

    // Requested lengths beyond the pattern register are cut to its width.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len_req,
                                                   input int max_len);
        if (int'(len_req) > max_len)
            return LEN_W'(max_len);
        else
            return len_req;
    endfunction

endpackage

// File: rtl/mealy_fsm_core.sv
// Five-state serial Mealy detector; z1 is combinational from the state and x1.
module mealy_fsm_core
    import mealy_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       x1,
    output logic       z1,
    output logic [2:0] y
);

    det_state_t state;
    det_state_t state_next;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= DET_A;
        else
            state <= state_next;
    end

    // C, E and any unused encoding fall back to A.
    always_comb begin
        state_next = DET_A;
        case (state)
            DET_A:   state_next = x1 ? DET_D : DET_B;
            DET_B:   state_next = x1 ? DET_E : DET_C;
            DET_D:   state_next = x1 ? DET_C : DET_E;
            default: state_next = DET_A;
        endcase
    end

    assign z1 = ((state == DET_E) && !x1) || ((state == DET_C) && x1);
    assign y  = state;

endmodule

// File: rtl/mealy_seq_ctrl.sv
// Start/done sequencer: clears the detector, shifts a stored pattern in LSB first
// and records which bits produced z1=1.
module mealy_seq_ctrl
    import mealy_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [PAT_W-1:0] load_data,
    input  logic [3:0]       load_len,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic [PAT_W-1:0] match_vec,
    output logic [2:0]       state_dbg
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    ctrl_state_t      state;
    ctrl_state_t      state_next;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [IDX_W-1:0] idx;
    logic             x1;
    logic             z1;
    logic             core_rst_n;
    logic             last_bit;

    assign last_bit   = (LEN_W'(idx) == (len - LEN_W'(1)));
    assign x1         = (state == RUN) ? pattern[idx] : 1'b0;
    assign core_rst_n = rst_n && (state != CLR);
    assign busy       = (state == CLR) || (state == RUN);
    assign done       = (state == DONE);

    mealy_fsm_core u_core (
        .clk   (clk),
        .rst_n (core_rst_n),
        .x1    (x1),
        .z1    (z1),
        .y     (state_dbg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // load has priority over start when both arrive in the same idle cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!load && start)
                    state_next = CLR;
            end
            CLR:     state_next = (len != '0) ? RUN : DONE;
            RUN: begin
                if (last_bit)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pattern   <= '0;
            len       <= '0;
            idx       <= '0;
            match_cnt <= '0;
            match_vec <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        pattern <= load_data;
                        len     <= clamp_len(load_len, PAT_W);
                    end
                end
                CLR: begin
                    idx       <= '0;
                    match_cnt <= '0;
                    match_vec <= '0;
                end
                RUN: begin
                    idx <= idx + IDX_W'(1);
                    if (z1) begin
                        match_vec[idx] <= 1'b1;
                        if (match_cnt != '1)
                            match_cnt <= match_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mealy_seq_ctrl.sv
// Scoreboard bench for mealy_seq_ctrl: a reference detector model predicts path,
// results and latency for each run.
module tb_mealy_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_data = '0;
    logic [3:0] load_len = '0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic [3:0] match_cnt;
    logic [7:0] match_vec;
    logic [2:0] state_dbg;

    typedef struct {
        logic [7:0]  vec;
        logic [3:0]  cnt;
        int          lat;
        int          len;
        logic [23:0] path;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mealy_seq_ctrl #(.PAT_W(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .load_len  (load_len),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .match_cnt (match_cnt),
        .match_vec (match_vec),
        .state_dbg (state_dbg)
    );

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [2:0] refNext(input logic [2:0] s, input logic x);
        case (s)
            3'b000:  return x ? 3'b010 : 3'b001;
            3'b001:  return x ? 3'b100 : 3'b011;
            3'b010:  return x ? 3'b011 : 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic exp_t refModel(input logic [7:0] pat, input logic [3:0] len_req);
        exp_t       e;
        logic [2:0] s;
        logic       x;
        e.len  = (len_req > 4'd8) ? 8 : int'(len_req);
        e.lat  = e.len + 2;
        e.vec  = '0;
        e.cnt  = '0;
        e.path = '0;
        s      = 3'b000;
        for (int i = 0; i < e.len; i++) begin
            x = pat[i[2:0]];
            e.path[i*3 +: 3] = s;
            if (((s == 3'b100) && !x) || ((s == 3'b011) && x)) begin
                e.vec[i[2:0]] = 1'b1;
                if (e.cnt != 4'hF)
                    e.cnt = e.cnt + 4'd1;
            end
            s = refNext(s, x);
        end
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // disturb > 0 raises start and load (with other data) during that cycle after start.
    task automatic applyStimulus(input string name, input logic [7:0] pat, input logic [3:0] len_req,
                                 input bit do_load, input int disturb);
        exp_t e;
        exp_t got;
        int   c;
        bit   seen;
        if (do_load) begin
            load = 1'b1; load_data = pat; load_len = len_req;
            tick;
            load = 1'b0;
        end
        e = refModel(pat, len_req);
        sb.push_back(e);
        start = 1'b1;
        tick;
        start = 1'b0;
        checkOutput({name, " busy_clr"}, 32'(busy), 32'd1);
        c = 1;
        seen = 1'b0;
        while (!seen && c < 40) begin
            if (c == disturb) begin
                start = 1'b1; load = 1'b1; load_data = ~pat; load_len = 4'd3;
            end
            tick;
            start = 1'b0;
            load = 1'b0;
            c++;
            if ((c - 2) < e.len)
                checkOutput({name, " path"}, 32'(state_dbg), 32'(e.path[(c-2)*3 +: 3]));
            if (done)
                seen = 1'b1;
        end
        checkOutput({name, " done_seen"}, 32'(seen), 32'd1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            checkOutput({name, " latency"}, 32'(c), 32'(got.lat));
            checkOutput({name, " match_vec"}, 32'(match_vec), 32'(got.vec));
            checkOutput({name, " match_cnt"}, 32'(match_cnt), 32'(got.cnt));
            checkOutput({name, " busy_done"}, 32'(busy), 32'd0);
        end else begin
            checkOutput({name, " scoreboard"}, 32'(sb.size()), 32'd1);
        end
        tick;
        checkOutput({name, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        bit any_done;

        rst_n = 1'b0;
        tick;
        tick;
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst match_cnt", 32'(match_cnt), 32'd0);
        checkOutput("rst match_vec", 32'(match_vec), 32'd0);
        checkOutput("rst state_dbg", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;
        tick;

        applyStimulus("p24", 8'h24, 4'd8, 1'b1, -1);
        applyStimulus("pFF", 8'hFF, 4'd6, 1'b1, -1);
        applyStimulus("p01", 8'h01, 4'd3, 1'b1, -1);
        applyStimulus("p00", 8'h00, 4'd6, 1'b1, -1);
        applyStimulus("len0", 8'hA5, 4'd0, 1'b1, -1);
        applyStimulus("clamp", 8'hFF, 4'd12, 1'b1, -1);

        load = 1'b1; start = 1'b1; load_data = 8'h01; load_len = 4'd3;
        tick;
        load = 1'b0; start = 1'b0;
        checkOutput("ldst busy", 32'(busy), 32'd0);
        tick;
        checkOutput("ldst busy2", 32'(busy), 32'd0);
        applyStimulus("ldst run", 8'h01, 4'd3, 1'b0, -1);

        applyStimulus("disturb", 8'h24, 4'd8, 1'b1, 4);
        applyStimulus("disturb rerun", 8'h24, 4'd8, 1'b0, -1);

        load = 1'b1; load_data = 8'h24; load_len = 4'd8;
        tick;
        load = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        checkOutput("midrst busy", 32'(busy), 32'd0);
        checkOutput("midrst done", 32'(done), 32'd0);
        checkOutput("midrst match_cnt", 32'(match_cnt), 32'd0);
        checkOutput("midrst match_vec", 32'(match_vec), 32'd0);
        checkOutput("midrst state_dbg", 32'(state_dbg), 32'd0);
        any_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done || busy)
                any_done = 1'b1;
        end
        checkOutput("midrst no_done", 32'(any_done), 32'd0);
        applyStimulus("postrst", 8'h00, 4'd0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
